serial_subtractor_16_bit: RTL and testbench

//   Bit-serial WIDTH-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first.

---
 rtl/serial_subtractor_16_bit_pkg.sv | 24 ++
 rtl/serial_subtractor_16_bit_if.sv | 53 +++++
 rtl/serial_subtractor_16_bit_full_adder.sv | 13 +
 rtl/serial_subtractor_16_bit.sv | 110 +++++++++++
 tb/tb_serial_subtractor_16_bit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_16_bit_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional flag outputs are enabled with the SERIAL_SUB_FLAGS_EN macro.
package sub_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } sub_state_t;

  localparam int CNT_W = $clog2(DEF_WIDTH);

  // Bit-count width for an arbitrary operand width (never below one bit).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_16_bit_if.sv
// Operand/result handshake bundle for serial_subtractor_16_bit.
// zero/ovf exist only when SERIAL_SUB_FLAGS_EN is defined.
interface serial_subtractor_16_bit_if #(
  parameter int WIDTH = 16
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  modport master (
    output start_valid,
    output a,
    output b,
    output b_in,
    output done_ready,
    input  start_ready,
    input  done_valid,
    input  diff,
`ifdef SERIAL_SUB_FLAGS_EN
    input  zero,
    input  ovf,
`endif
    input  b_out
  );

  modport slave (
    input  start_valid,
    input  a,
    input  b,
    input  b_in,
    input  done_ready,
    output start_ready,
    output done_valid,
    output diff,
`ifdef SERIAL_SUB_FLAGS_EN
    output zero,
    output ovf,
`endif
    output b_out
  );

endinterface

// File: rtl/serial_subtractor_16_bit_full_adder.sv
// One-bit full adder used as the single serial arithmetic cell.
module full_adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_subtractor_16_bit.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one bit per clock.
// Optional zero/ovf flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtractor_16_bit
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  serial_subtractor_16_bit_if.slave bus
);

  localparam int                CNT_BITS = cnt_width(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST   = CNT_BITS'(WIDTH - 1);

  sub_state_t          state_reg;
  sub_state_t          state_next;
  logic [WIDTH-1:0]    opa_reg;
  logic [WIDTH-1:0]    opb_reg;
  logic [WIDTH-1:0]    res_reg;
  logic                carry_reg;
  logic [CNT_BITS-1:0] cnt_reg;
  logic                start_ready_reg;

  logic fa_s;
  logic fa_c;
  logic accept;
  logic done_valid;

  // Subtraction as a + ~b + ~b_in: operand b and the borrow are inverted at load.
  full_adder_1_bit u_cell (
    .a     (opa_reg[0]),
    .b     (opb_reg[0]),
    .c_in  (carry_reg),
    .s     (fa_s),
    .c_out (fa_c)
  );

  assign accept     = bus.start_valid & start_ready_reg;
  assign done_valid = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    if (bus.done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      opa_reg         <= '0;
      opb_reg         <= '0;
      res_reg         <= '0;
      carry_reg       <= 1'b0;
      cnt_reg         <= '0;
      start_ready_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      start_ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            opa_reg   <= bus.a;
            opb_reg   <= ~bus.b;
            carry_reg <= ~bus.b_in;
            res_reg   <= '0;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
          opa_reg   <= {1'b0, opa_reg[WIDTH-1:1]};
          opb_reg   <= {1'b0, opb_reg[WIDTH-1:1]};
          carry_reg <= fa_c;
          cnt_reg   <= cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = start_ready_reg;
  assign bus.done_valid  = done_valid;
  // Results are forced to zero whenever no result is being offered.
  assign bus.diff        = done_valid ? res_reg : '0;
  assign bus.b_out       = done_valid & ~carry_reg;

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb_reg;
  logic b_msb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
    end else if (state_reg == IDLE && accept) begin
      a_msb_reg <= bus.a[WIDTH-1];
      b_msb_reg <= bus.b[WIDTH-1];
    end
  end

  assign bus.zero = done_valid & (res_reg == '0);
  assign bus.ovf  = done_valid & (a_msb_reg != b_msb_reg) & (res_reg[WIDTH-1] != a_msb_reg);
`endif

endmodule

// File: tb/tb_serial_subtractor_16_bit.sv
// Scoreboard bench for serial_subtractor_16_bit: accepted operands push a
// reference result, a monitor pops and compares on each result handshake.
module tb_serial_subtractor_16_bit;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         b_out;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  int   accept_cyc = 0;
  int   rdy_mode = 0;
  exp_t q[$];

  serial_subtractor_16_bit_if #(.WIDTH(W)) bus ();

  serial_subtractor_16_bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t   r;
    longint d;
    d       = longint'(a) - longint'(b) - longint'(bin);
    r.diff  = d[W-1:0];
    r.b_out = (d < 0);
    r.zero  = (d[W-1:0] == '0);
    r.ovf   = (a[W-1] != b[W-1]) && (r.diff[W-1] != a[W-1]);
    return r;
  endfunction

  // Consumer readiness pattern: 0 always ready, 1 random, 2 stalled.
  initial begin
    bus.done_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.done_ready = 1'b1;
        1:       bus.done_ready = 1'($urandom_range(0, 1));
        default: bus.done_ready = 1'b0;
      endcase
    end
  end

  // Accept monitor: a handshake seen here completes on the next rising edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.start_valid && bus.start_ready) begin
      q.push_back(model(bus.a, bus.b, bus.b_in));
      accept_cyc = cyc + 1;
      $display("accept a=0x%04h b=0x%04h b_in=%0d", bus.a, bus.b, bus.b_in);
    end
  end

  // Result monitor.
  initial begin : result_mon
    logic         prev_dv;
    logic         stalled;
    logic [W-1:0] prev_diff;
    logic         prev_bout;
    exp_t         e;
    prev_dv = 1'b0;
    stalled = 1'b0;
    prev_diff = '0;
    prev_bout = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_dv = 1'b0;
        stalled = 1'b0;
        continue;
      end
      if (bus.done_valid && !prev_dv)
        check("latency_edges", cyc - accept_cyc + 1, W + 1);
      if (stalled && bus.done_valid) begin
        check("hold_diff", bus.diff, prev_diff);
        check("hold_b_out", bus.b_out, prev_bout);
      end
      if (bus.done_valid && bus.done_ready) begin
        check("result_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          $display("result diff=0x%04h b_out=%0d (exp 0x%04h/%0d)", bus.diff, bus.b_out, e.diff, e.b_out);
          check("diff", bus.diff, e.diff);
          check("b_out", bus.b_out, e.b_out);
`ifdef SERIAL_SUB_FLAGS_EN
          check("zero", bus.zero, e.zero);
          check("ovf", bus.ovf, e.ovf);
`endif
        end
      end else if (!bus.done_valid) begin
        check("gate_diff", bus.diff, 0);
        check("gate_b_out", bus.b_out, 0);
      end
      stalled   = bus.done_valid && !bus.done_ready;
      prev_dv   = bus.done_valid;
      prev_diff = bus.diff;
      prev_bout = bus.b_out;
    end
  end

  // Entered and left at posedge+1.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int t = 0;
    while (!bus.start_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("start_ready_wait", bus.start_ready, 1);
    bus.start_valid = 1'b1;
    bus.a    = a;
    bus.b    = b;
    bus.b_in = bin;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.a    = W'($urandom);
    bus.b    = W'($urandom);
    bus.b_in = 1'($urandom);
  endtask

  task automatic wait_dv();
    int t = 0;
    while (!bus.done_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_valid_wait", bus.done_valid, 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !bus.start_ready) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_queue", q.size(), 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_done_valid", bus.done_valid, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_b_out", bus.b_out, 0);
    check("rst_start_ready", bus.start_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("start_ready_after_rst", bus.start_ready, 1);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.b_in        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_start_ready", bus.start_ready, 0);
    check("reset_done_valid", bus.done_valid, 0);
    check("reset_diff", bus.diff, 0);
    check("reset_b_out", bus.b_out, 0);
`ifdef SERIAL_SUB_FLAGS_EN
    check("reset_zero", bus.zero, 0);
    check("reset_ovf", bus.ovf, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_start_ready", bus.start_ready, 1);

    // Directed corner operations, consumer always ready.
    rdy_mode = 0;
    do_op(16'h0005, 16'h0003, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0);
    do_op(16'h0010, 16'h000F, 1'b1);
    do_op(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // Stalled consumer: result holds and new operands are refused.
    rdy_mode = 2;
    do_op(16'h1357, 16'h2468, 1'b0);
    wait_dv();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.start_valid = 1'b1;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      @(negedge clk);
      check("stall_start_ready", bus.start_ready, 0);
      check("stall_done_valid", bus.done_valid, 1);
    end
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // Reset in RUN cycle 8 aborts the operation.
    do_op(W'($urandom), W'($urandom), 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset_pulse();

    // Reset while a stalled result is presented.
    rdy_mode = 2;
    do_op(16'hABCD, 16'h0123, 1'b1);
    wait_dv();
    reset_pulse();
    rdy_mode = 0;

    do_op(16'h1234, 16'h0234, 1'b0);
    drain();

    // Randomized operands with a random consumer.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom));
    rdy_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
